axi_dram_rd_slave: RTL



---
 rtl/axi_dram_rd_slave.sv | 110 +++++++++++
 1 files changed

// File: rtl/axi_dram_rd_slave.sv
// AXI4 read-only responder modelling off-chip DRAM: one AR at a time, fixed access
// latency, then len+1 beats from a backdoor-loadable word array.
module axi_dram_rd_slave #(
    parameter int ADDR_W     = 31,
    parameter int DEPTH_LOG2 = 12,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            axi_arid,
    input  logic [ADDR_W-1:0]     axi_araddr,
    input  logic [7:0]            axi_arlen,
    input  logic [2:0]            axi_arsize,
    input  logic [1:0]            axi_arburst,
    input  logic                  axi_arvalid,
    output logic                  axi_arready,
    output logic [7:0]            axi_rid,
    output logic [31:0]           axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    input  logic                  ld_wen,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t              state, next_state;
    logic [7:0]          id_q, len_q, beat_cnt;
    logic [ADDR_W-1:0]   cur_addr;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic [3:0]          lat_cnt;
    logic [31:0]         mem [2**DEPTH_LOG2];
    logic                ar_hs, r_hs, slv_err, dec_err, last_beat;

    assign ar_hs     = (state == IDLE) && axi_arvalid;
    assign r_hs      = (state == BURST) && axi_rready;
    assign last_beat = (beat_cnt == len_q);
    // Unsupported size/burst type outranks an out-of-range address.
    assign slv_err   = (size_q > 3'd2) || burst_q[1];
    assign dec_err   = |cur_addr[ADDR_W-1:DEPTH_LOG2+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rid     = '0;
        axi_rdata   = '0;
        axi_rresp   = 2'b00;
        axi_rlast   = 1'b0;
        case (state)
            IDLE: begin
                axi_arready = 1'b1;
                if (axi_arvalid) next_state = (RD_LAT > 0) ? WAIT : BURST;
            end
            WAIT: begin
                if (lat_cnt == 4'd1) next_state = BURST;
            end
            BURST: begin
                axi_rvalid = 1'b1;
                axi_rid    = id_q;
                axi_rlast  = last_beat;
                if (slv_err)      axi_rresp = 2'b10;
                else if (dec_err) axi_rresp = 2'b11;
                else              axi_rdata = mem[cur_addr[DEPTH_LOG2+1:2]];
                if (axi_rready && last_beat) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            cur_addr <= '0;
            lat_cnt  <= '0;
            beat_cnt <= '0;
        end else if (ar_hs) begin
            id_q     <= axi_arid;
            len_q    <= axi_arlen;
            size_q   <= axi_arsize;
            burst_q  <= axi_arburst;
            cur_addr <= axi_araddr;
            lat_cnt  <= 4'(RD_LAT);
            beat_cnt <= '0;
        end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
        end else if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (burst_q == 2'b01) cur_addr <= cur_addr + (ADDR_W'(1) << size_q);
        end
    end

    // Backdoor load; deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_wen) mem[ld_addr] <= ld_data;
    end

endmodule
